// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-macro signals of the arbiter, grouped as one bundle.
// Optional bus_err exists only when MEM_PORT_ARBITER_TIMEOUT_EN is defined.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  logic              bus_err;
`endif

  // Arbiter side: takes requests and memory responses, drives grants and the memory bus.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_size, mem_addr, mem_wdata
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    , output bus_err
`endif
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_size, mem_addr, mem_wdata
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    , input bus_err
`endif
  );

endinterface

// File: rtl/mem_port_arb_sel.sv
// Fixed-priority D-over-I selection with a starvation counter that forces I through.
// o_grant is one-hot: bit 0 = fetch, bit 1 = data.
module mem_port_arb_sel #(
  parameter int STARVE_MAX = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_fetch_req,
  input  logic       i_data_req,
  input  logic       i_arbitrate,
  output logic [1:0] o_grant
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] r_starve;

  always_comb begin
    o_grant = 2'b00;
    if (i_arbitrate) begin
      if (i_data_req && (r_starve < STARVE_LIM)) begin
        o_grant = 2'b10;
      end else if (i_fetch_req) begin
        o_grant = 2'b01;
      end else if (i_data_req) begin
        o_grant = 2'b10;
      end
    end
  end

  // Only counts D wins that actually held a pending fetch back.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_starve <= 4'd0;
    end else if (i_arbitrate) begin
      if (!i_fetch_req || o_grant[0]) begin
        r_starve <= 4'd0;
      end else if (o_grant[1] && (r_starve < STARVE_LIM)) begin
        r_starve <= r_starve + 4'd1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch (I) and data (D) requesters: IDLE -> BUSY -> RESP.
// Define MEM_PORT_ARBITER_TIMEOUT_EN to add the BUSY watchdog and bus_err output.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_MAX     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mem_port_arbiter: STARVE_MAX must be 1..15 and TIMEOUT_CYCLES >= 1");
  end

  state_t            r_state;
  state_t            w_state_next;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [1:0]        r_size;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic [1:0]        w_grant;
  logic              w_arbitrate;
  logic              w_timeout;
  logic              w_finish;
  logic [DATA_W-1:0] w_resp_data;

  assign w_arbitrate = (r_state == IDLE) && !reset;

  mem_port_arb_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_sel (
    .clock       (clock),
    .reset       (reset),
    .i_fetch_req (bus.i_req),
    .i_data_req  (bus.d_req),
    .i_arbitrate (w_arbitrate),
    .o_grant     (w_grant)
  );

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err;

  assign w_timeout = (r_state == BUSY) && !bus.mem_ready &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // r_err is set only on the BUSY->RESP abort edge, so it is high for that RESP cycle alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_tmo_cnt <= (r_state == BUSY) ? r_tmo_cnt + 1'b1 : '0;
      r_err     <= w_timeout;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_finish    = (r_state == BUSY) && (bus.mem_ready || w_timeout);
  assign w_resp_data = (bus.mem_ready && !r_we) ? bus.mem_rdata : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    bus.i_gnt     = w_grant[0];
    bus.d_gnt     = w_grant[1];
    bus.i_rvalid  = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_size  = 2'b00;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    bus.bus_err   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (|w_grant) begin
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = r_we;
        bus.mem_size  = r_size;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
        if (w_finish) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        bus.i_rvalid = (r_owner == OWN_I);
        bus.d_rvalid = (r_owner == OWN_D);
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
        bus.bus_err  = r_err;
`endif
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Transaction latch plus per-requester response data, which holds between pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner   <= OWN_I;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_size    <= 2'b00;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_grant[1]) begin
        r_owner <= OWN_D;
        r_addr  <= bus.d_addr;
        r_we    <= bus.d_we;
        r_size  <= bus.d_size;
        r_wdata <= bus.d_wdata;
      end else if (w_grant[0]) begin
        r_owner <= OWN_I;
        r_addr  <= bus.i_addr;
        r_we    <= 1'b0;
        r_size  <= SZ_WORD;
        r_wdata <= '0;
      end
      if (w_finish) begin
        if (r_owner == OWN_I) begin
          r_i_rdata <= w_resp_data;
        end else begin
          r_d_rdata <= w_resp_data;
        end
      end
    end
  end

  assign bus.i_rdata = r_i_rdata;
  assign bus.d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the timeout scenario runs only when
// MEM_PORT_ARBITER_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .STARVE_MAX     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic idle_inputs();
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_size    = SZ_WORD;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    n_tests++;
    if ({bus.i_gnt, bus.d_gnt} !== 2'b00) begin
      n_fail++; $display("FAIL reset_gnt: got %b want 00", {bus.i_gnt, bus.d_gnt});
    end
    n_tests++;
    if ({bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata, bus.mem_en, bus.mem_we,
         bus.mem_size, bus.mem_addr, bus.mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: en=%b we=%b addr=%h wdata=%h irdata=%h drdata=%h want all 0",
                         bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata);
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    $display("[TB] reset: outputs idle");
  endtask

  task automatic test_single_fetch();
    @(negedge clock);
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0100_0000;
    #1;
    n_tests++;
    if ({bus.i_gnt, bus.d_gnt, bus.mem_en} !== 3'b100) begin
      n_fail++; $display("FAIL fetch_gnt: got ignt,dgnt,en=%b want 100", {bus.i_gnt, bus.d_gnt, bus.mem_en});
    end
    @(negedge clock);
    bus.i_req     = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0000_0013;
    #1;
    n_tests++;
    if ({bus.mem_en, bus.mem_we, bus.mem_size, bus.mem_addr, bus.i_rvalid} !==
        {1'b1, 1'b0, SZ_WORD, 32'h0100_0000, 1'b0}) begin
      n_fail++; $display("FAIL fetch_busy: got en=%b we=%b size=%b addr=%h rv=%b want 1 0 10 01000000 0",
                         bus.mem_en, bus.mem_we, bus.mem_size, bus.mem_addr, bus.i_rvalid);
    end
    @(negedge clock);
    bus.mem_ready = 1'b0;
    #1;
    n_tests++;
    if ({bus.i_rvalid, bus.d_rvalid, bus.mem_en, bus.i_rdata} !== {3'b100, 32'h0000_0013}) begin
      n_fail++; $display("FAIL fetch_resp: got irv,drv,en=%b rdata=%h want 100 00000013",
                         {bus.i_rvalid, bus.d_rvalid, bus.mem_en}, bus.i_rdata);
    end
    @(negedge clock);
    #1;
    n_tests++;
    if ({bus.i_rvalid, bus.i_rdata} !== {1'b0, 32'h0000_0013}) begin
      n_fail++; $display("FAIL fetch_hold: got rv=%b rdata=%h want 0 00000013", bus.i_rvalid, bus.i_rdata);
    end
    $display("[TB] single fetch: addr=01000000 rdata=%h", bus.i_rdata);
  endtask

  task automatic test_simultaneous();
    @(negedge clock);
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_size = SZ_WORD;
    bus.d_addr = 32'h0100_0100;
    #1;
    n_tests++;
    if ({bus.i_gnt, bus.d_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL simul_first: got ignt,dgnt=%b want 01", {bus.i_gnt, bus.d_gnt});
    end
    @(negedge clock);
    bus.d_req     = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    #1;
    n_tests++;
    if ({bus.mem_en, bus.mem_addr, bus.i_gnt} !== {1'b1, 32'h0100_0100, 1'b0}) begin
      n_fail++; $display("FAIL simul_busy: got en=%b addr=%h ignt=%b want 1 01000100 0",
                         bus.mem_en, bus.mem_addr, bus.i_gnt);
    end
    @(negedge clock);
    bus.mem_ready = 1'b0;
    #1;
    n_tests++;
    if ({bus.i_rvalid, bus.d_rvalid, bus.i_gnt, bus.d_rdata} !== {3'b010, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL simul_dresp: got irv,drv,ignt=%b drdata=%h want 010 cafef00d",
                         {bus.i_rvalid, bus.d_rvalid, bus.i_gnt}, bus.d_rdata);
    end
    @(negedge clock);
    #1;
    n_tests++;
    if ({bus.i_gnt, bus.d_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL simul_second: got ignt,dgnt=%b want 10", {bus.i_gnt, bus.d_gnt});
    end
    @(negedge clock);
    bus.i_req     = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0000_0093;
    #1;
    n_tests++;
    if ({bus.mem_we, bus.mem_size, bus.mem_addr} !== {1'b0, SZ_WORD, 32'h0100_0000}) begin
      n_fail++; $display("FAIL simul_ibusy: got we=%b size=%b addr=%h want 0 10 01000000",
                         bus.mem_we, bus.mem_size, bus.mem_addr);
    end
    @(negedge clock);
    bus.mem_ready = 1'b0;
    #1;
    n_tests++;
    if ({bus.i_rvalid, bus.i_rdata, bus.d_rdata} !== {1'b1, 32'h0000_0093, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL simul_iresp: got rv=%b irdata=%h drdata=%h want 1 00000093 cafef00d",
                         bus.i_rvalid, bus.i_rdata, bus.d_rdata);
    end
    $display("[TB] simultaneous: D then I granted");
  endtask

  task automatic test_starvation();
    logic [1:0] want;
    @(negedge clock);
    bus.i_req     = 1'b1;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_size    = SZ_HALF;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h2468_ACE0;
    for (int k = 0; k < 10; k++) begin
      #1;
      want = (k == 4 || k == 9) ? 2'b10 : 2'b01;
      n_tests++;
      if ({bus.i_gnt, bus.d_gnt} !== want) begin
        n_fail++; $display("FAIL starve_grant[%0d]: got ignt,dgnt=%b want %b", k, {bus.i_gnt, bus.d_gnt}, want);
      end
      $display("[TB] starvation grant %0d: ignt,dgnt=%b", k, {bus.i_gnt, bus.d_gnt});
      if (k < 9) begin
        repeat (3) @(negedge clock);
      end
    end
    @(negedge clock);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clock);
    bus.mem_ready = 1'b0;
    #1;
    n_tests++;
    if ({bus.i_rvalid, bus.d_rvalid, bus.i_rdata} !== {2'b10, 32'h2468_ACE0}) begin
      n_fail++; $display("FAIL starve_last: got irv,drv=%b irdata=%h want 10 2468ace0",
                         {bus.i_rvalid, bus.d_rvalid}, bus.i_rdata);
    end
  endtask

  task automatic test_store_wait();
    @(negedge clock);
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_size  = SZ_BYTE;
    bus.d_addr  = 32'h0100_0200;
    bus.d_wdata = 32'h0000_00AB;
    #1;
    n_tests++;
    if ({bus.i_gnt, bus.d_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL store_gnt: got ignt,dgnt=%b want 01", {bus.i_gnt, bus.d_gnt});
    end
    @(negedge clock);
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_size    = SZ_WORD;
    bus.d_addr    = 32'hFFFF_FFFF;
    bus.d_wdata   = 32'h1234_5678;
    bus.mem_rdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 5; c++) begin
      bus.mem_ready = (c == 4);
      #1;
      n_tests++;
      if ({bus.mem_en, bus.mem_we, bus.mem_size, bus.mem_addr, bus.mem_wdata, bus.d_rvalid} !==
          {1'b1, 1'b1, SZ_BYTE, 32'h0100_0200, 32'h0000_00AB, 1'b0}) begin
        n_fail++; $display("FAIL store_busy[%0d]: got en=%b we=%b size=%b addr=%h wdata=%h rv=%b want 1 1 00 01000200 000000ab 0",
                           c, bus.mem_en, bus.mem_we, bus.mem_size, bus.mem_addr, bus.mem_wdata, bus.d_rvalid);
      end
      @(negedge clock);
    end
    bus.mem_ready = 1'b0;
    #1;
    n_tests++;
    if ({bus.d_rvalid, bus.mem_en, bus.d_rdata} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL store_resp: got rv=%b en=%b drdata=%h want 1 0 00000000",
                         bus.d_rvalid, bus.mem_en, bus.d_rdata);
    end
    $display("[TB] store with 5 wait cycles: drdata=%h", bus.d_rdata);
  endtask

  task automatic test_reset_busy();
    @(negedge clock);
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0100_0300;
    #1;
    n_tests++;
    if (bus.i_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rstbusy_gnt: got %b want 1", bus.i_gnt);
    end
    @(negedge clock);
    bus.i_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_tests++;
    if ({bus.mem_en, bus.mem_addr} !== {1'b1, 32'h0100_0300}) begin
      n_fail++; $display("FAIL rstbusy_busy2: got en=%b addr=%h want 1 01000300", bus.mem_en, bus.mem_addr);
    end
    @(negedge clock);
    reset         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0000_1111;
    #1;
    n_tests++;
    if ({bus.mem_en, bus.i_rvalid, bus.d_rvalid, bus.i_rdata} !== {3'b000, 32'h0}) begin
      n_fail++; $display("FAIL rstbusy_after: got en,irv,drv=%b irdata=%h want 000 00000000",
                         {bus.mem_en, bus.i_rvalid, bus.d_rvalid}, bus.i_rdata);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1;
      n_tests++;
      if ({bus.mem_en, bus.i_rvalid, bus.d_rvalid} !== 3'b000) begin
        n_fail++; $display("FAIL rstbusy_quiet[%0d]: got en,irv,drv=%b want 000", c,
                           {bus.mem_en, bus.i_rvalid, bus.d_rvalid});
      end
    end
    bus.mem_ready = 1'b0;
    @(negedge clock);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_size = 2'b11;
    bus.d_addr = 32'h0100_0403;
    #1;
    n_tests++;
    if ({bus.i_gnt, bus.d_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL rstbusy_regnt: got ignt,dgnt=%b want 01", {bus.i_gnt, bus.d_gnt});
    end
    @(negedge clock);
    bus.d_req     = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h55AA_55AA;
    #1;
    n_tests++;
    if ({bus.mem_size, bus.mem_addr} !== {2'b11, 32'h0100_0403}) begin
      n_fail++; $display("FAIL size11_pass: got size=%b addr=%h want 11 01000403", bus.mem_size, bus.mem_addr);
    end
    @(negedge clock);
    bus.mem_ready = 1'b0;
    #1;
    n_tests++;
    if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'h55AA_55AA}) begin
      n_fail++; $display("FAIL rstbusy_load: got rv=%b drdata=%h want 1 55aa55aa", bus.d_rvalid, bus.d_rdata);
    end
    $display("[TB] reset in busy: abandoned, next load drdata=%h", bus.d_rdata);
  endtask

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clock);
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0100_0500;
    @(negedge clock);
    bus.i_req     = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0000_0077;
    @(negedge clock);
    bus.mem_ready = 1'b0;
    #1;
    n_tests++;
    if ({bus.i_rvalid, bus.bus_err, bus.i_rdata} !== {2'b10, 32'h0000_0077}) begin
      n_fail++; $display("FAIL tmo_prefetch: got rv=%b err=%b rdata=%h want 1 0 00000077",
                         bus.i_rvalid, bus.bus_err, bus.i_rdata);
    end
    @(negedge clock);
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0100_0504;
    @(negedge clock);
    bus.i_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_tests++;
      if ({bus.mem_en, bus.bus_err, bus.i_rvalid} !== 3'b100) begin
        n_fail++; $display("FAIL tmo_busy[%0d]: got en,err,rv=%b want 100", c,
                           {bus.mem_en, bus.bus_err, bus.i_rvalid});
      end
      @(negedge clock);
    end
    #1;
    n_tests++;
    if ({bus.i_rvalid, bus.bus_err, bus.mem_en, bus.i_rdata} !== {3'b110, 32'h0}) begin
      n_fail++; $display("FAIL tmo_resp: got rv,err,en=%b rdata=%h want 110 00000000",
                         {bus.i_rvalid, bus.bus_err, bus.mem_en}, bus.i_rdata);
    end
    @(negedge clock);
    #1;
    n_tests++;
    if ({bus.i_rvalid, bus.bus_err} !== 2'b00) begin
      n_fail++; $display("FAIL tmo_after: got rv,err=%b want 00", {bus.i_rvalid, bus.bus_err});
    end
    $display("[TB] timeout: aborted after 8 busy cycles");
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_store_wait();
    test_reset_busy();
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
